alu_exec_unit: RTL and testbench

Execute-stage ALU that consumes the 4-bit ALU_ctrl code from the ALU control decoder, together with the two operands from the register-read/immediate mux. Logic and shift ops complete in one cycle. MUL uses an iterative shift-add engine, which stalls the pipeline via in_ready. Results and the zero flag are registered and qualified by out_valid for the writeback/branch logic.

---
 rtl/alu_exec_unit.sv | 129 ++++++++++++
 tb/tb_alu_exec_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/shift/add ops plus an iterative
// shift-add multiplier that stalls the requester through in_ready.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALU_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;

  localparam int             CW       = SHW + 1;
  localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_alu_res;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_idle;
  logic             w_last;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_last    = (r_cnt == CNT_ONE);
  assign in_ready  = w_idle;
  assign busy      = ~w_idle;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;

  // Single-cycle datapath; MUL and unused codes produce zero here.
  always_comb begin
    w_alu_res = {WIDTH{1'b0}};
    case (ALU_ctrl)
      OP_ADD:  w_alu_res = a + b;
      OP_SUB:  w_alu_res = a - b;
      OP_AND:  w_alu_res = a & b;
      OP_OR:   w_alu_res = a | b;
      OP_XOR:  w_alu_res = a ^ b;
      OP_SLL:  w_alu_res = a << b[SHW-1:0];
      OP_SRL:  w_alu_res = a >> b[SHW-1:0];
      default: w_alu_res = {WIDTH{1'b0}};
    endcase
  end

  // One shift-add step of the multiplier.
  always_comb begin
    w_acc_next = r_acc;
    if (r_mplier[0]) begin
      w_acc_next = r_acc + r_mcand;
    end else begin
      w_acc_next = r_acc;
    end
  end

  // Control FSM, result registers and multiplier datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_result    <= {WIDTH{1'b0}};
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
      r_acc       <= {WIDTH{1'b0}};
      r_mcand     <= {WIDTH{1'b0}};
      r_mplier    <= {WIDTH{1'b0}};
      r_cnt       <= {CW{1'b0}};
    end else begin
      r_out_valid <= 1'b0;
      if (flush) begin
        // Kill wins over accept and over a same-edge MUL completion.
        r_state <= ST_IDLE;
      end else if (r_state == ST_IDLE) begin
        if (in_valid) begin
          if (ALU_ctrl == OP_MUL) begin
            r_acc    <= {WIDTH{1'b0}};
            r_mcand  <= a;
            r_mplier <= b;
            r_cnt    <= CNT_FULL;
            r_state  <= ST_MUL;
          end else begin
            r_result    <= w_alu_res;
            r_zero      <= (w_alu_res == {WIDTH{1'b0}});
            r_out_valid <= 1'b1;
          end
        end
      end else begin
        r_acc    <= w_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt - CNT_ONE;
        if (w_last) begin
          r_result    <= w_acc_next;
          r_zero      <= (w_acc_next == {WIDTH{1'b0}});
          r_out_valid <= 1'b1;
          r_state     <= ST_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench: directed test-plan sequences with literal expectations,
// then random traffic, all compared every cycle against a cycle-count model.
module tb_alu_exec_unit;
  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    ALU_ctrl;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          flush;
  logic          out_valid;
  logic [W-1:0]  result;
  logic          zero;
  logic          busy;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALU_ctrl(ALU_ctrl), .a(a), .b(b), .flush(flush), .out_valid(out_valid),
    .result(result), .zero(zero), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] p;
    int sh;
    sh = int'(y % W);
    p  = {32'd0, x} * {32'd0, y};
    case (c)
      4'b0010: return x + y;
      4'b0110: return x - y;
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0111: return x ^ y;
      4'b0100: return x << sh;
      4'b0101: return x >> sh;
      4'b0011: return p[W-1:0];
      default: return {W{1'b0}};
    endcase
  endfunction

  // Reference model: a MUL accepted at cycle c finishes at cycle c+W.
  longint      cyc = 0;
  longint      m_done;
  logic        m_mul;
  logic [W-1:0] m_prod;
  logic [W-1:0] m_result;
  logic        m_zero;
  logic        m_valid;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      m_mul <= 1'b0; m_result <= '0; m_zero <= 1'b0; m_valid <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      if (flush) begin
        m_mul <= 1'b0;
      end else if (m_mul) begin
        if (cyc == m_done) begin
          m_result <= m_prod; m_zero <= (m_prod == '0); m_valid <= 1'b1; m_mul <= 1'b0;
        end
      end else if (in_valid) begin
        if (ALU_ctrl == 4'b0011) begin
          m_mul <= 1'b1; m_done <= cyc + W; m_prod <= ref_op(ALU_ctrl, a, b);
        end else begin
          m_result <= ref_op(ALU_ctrl, a, b);
          m_zero   <= (ref_op(ALU_ctrl, a, b) == '0);
          m_valid  <= 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    chk("out_valid", W'(out_valid), W'(m_valid));
    chk("in_ready",  W'(in_ready),  W'(!m_mul));
    chk("busy",      W'(busy),      W'(m_mul));
    chk("result",    result,        m_result);
    chk("zero",      W'(zero),      W'(m_zero));
  end

  // Issue one op, hold until accepted, then check literal result and latency.
  task automatic run_op(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] exp_r, input logic exp_z, input int exp_lat,
                        input string nm);
    int n;
    @(negedge clk);
    in_valid = 1'b1; ALU_ctrl = c; a = x; b = y;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    chk({nm, "_ready_timeout"}, W'(in_ready), W'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk({nm, "_ov"}, W'(out_valid), W'(1));
    chk({nm, "_lat"}, W'(n), W'(exp_lat));
    chk({nm, "_res"}, result, exp_r);
    chk({nm, "_zero"}, W'(zero), W'(exp_z));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; ALU_ctrl = 4'b0000; a = '0; b = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", result, 32'h0);
    chk("rst_ov", W'(out_valid), W'(0));
    @(negedge clk); rst_n = 1'b1;

    // Test 1
    run_op(4'b0010, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b1, 0, "add_wrap");
    run_op(4'b0110, 32'd5, 32'd5, 32'h0, 1'b1, 0, "sub_eq");
    run_op(4'b0110, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 0, "sub_neg");
    // Test 2
    run_op(4'b0100, 32'd1, 32'h2F, 32'h0000_8000, 1'b0, 0, "sll");
    run_op(4'b0101, 32'h8000_0000, 32'd31, 32'h1, 1'b0, 0, "srl");
    run_op(4'b0000, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0, 0, "and");
    run_op(4'b0001, 32'hF0F0, 32'hFF00, 32'hFFF0, 1'b0, 0, "or");
    run_op(4'b0111, 32'hF0F0, 32'hFF00, 32'h0FF0, 1'b0, 0, "xor");
    run_op(4'b1111, 32'h1234, 32'h5678, 32'h0, 1'b1, 0, "bad_op");
    // Test 3
    run_op(4'b0011, 32'd7, 32'd6, 32'd42, 1'b0, W, "mul_7x6");
    run_op(4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, W, "mul_ff");

    // Test 4: add held while MUL is busy
    @(negedge clk);
    in_valid = 1'b1; ALU_ctrl = 4'b0011; a = 32'd7; b = 32'd6;
    @(posedge clk); #1;
    ALU_ctrl = 4'b0010; a = 32'd1; b = 32'd1;
    repeat (10) @(negedge clk);
    chk("stall_busy", W'(busy), W'(1));
    run_op(4'b0010, 32'd1, 32'd1, 32'd2, 1'b0, 0, "add_after_mul");

    // Test 5: flush mid-MUL, then flush with a coincident add
    @(negedge clk);
    in_valid = 1'b1; ALU_ctrl = 4'b0011; a = 32'd3; b = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_ready", W'(in_ready), W'(1));
    chk("flush_keep", result, 32'd2);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; ALU_ctrl = 4'b0010; a = 32'd8; b = 32'd8;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_drop_ov", W'(out_valid), W'(0));
    chk("flush_drop_res", result, 32'd2);
    repeat (40) @(posedge clk);

    // Test 6: reset mid-MUL
    @(negedge clk);
    in_valid = 1'b1; ALU_ctrl = 4'b0011; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", W'(busy), W'(0));
    chk("arst_result", result, 32'h0);
    chk("arst_ov", W'(out_valid), W'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(4'b0010, 32'd2, 32'd2, 32'd4, 1'b0, 0, "add_post_rst");
    repeat (40) @(posedge clk);

    // Random traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0, 1:    ALU_ctrl = 4'b0011;
        2:       ALU_ctrl = 4'(($urandom_range(0, 7) | 8));
        default: ALU_ctrl = 4'($urandom_range(0, 7));
      endcase
      case ($urandom_range(0, 4))
        0:       a = 32'h0;
        1:       a = 32'hFFFF_FFFF;
        2:       a = 32'h8000_0000;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(0, 63));
        default: b = $urandom;
      endcase
      flush = ($urandom_range(0, 59) == 0);
      rst_n = ($urandom_range(0, 999) != 0);
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
